// File: rtl/imiss_merge_queue.sv
// Instruction-miss queue: tracks outstanding line fetches in a circular buffer,
// merging same-line requests from different threads so one response wakes them all.
`timescale 1ns/1ps
module imiss_merge_queue #(
  parameter int NUM_THREADS = 8,
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 32,
  parameter int OFFSET_W    = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_address,
  input  logic [NUM_THREADS-1:0]   req_thread_oh,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_address,
  output logic [NUM_THREADS-1:0]   out_thread_mask,
  input  logic                     resp_valid,
  output logic [ADDR_W-1:0]        resp_address,
  output logic [NUM_THREADS-1:0]   resp_thread_mask,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     error
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LINE_W = ADDR_W - OFFSET_W;

  logic [DEPTH-1:0]       valid_r;
  logic [DEPTH-1:0]       issued_r;
  logic [LINE_W-1:0]      line_r [DEPTH];
  logic [NUM_THREADS-1:0] mask_r [DEPTH];
  logic [PTR_W-1:0]       tail_r;
  logic [PTR_W-1:0]       issue_ptr_r;
  logic [PTR_W-1:0]       retire_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic                   error_r;

  logic [LINE_W-1:0] req_line_s;
  logic              head_issuable_s;
  logic              retire_ready_s;
  logic              retire_s;
  logic              error_set_s;
  logic              hit_s;
  logic [PTR_W-1:0]  hit_idx_s;
  logic              full_s;
  logic              accept_s;
  logic              alloc_s;
  logic              merge_s;
  logic              issue_s;
  logic              unused_offset_s;

  assign req_line_s      = req_address[ADDR_W-1:OFFSET_W];
  assign unused_offset_s = ^req_address[OFFSET_W-1:0];

  assign head_issuable_s = valid_r[issue_ptr_r] & ~issued_r[issue_ptr_r];
  assign retire_ready_s  = valid_r[retire_ptr_r] & issued_r[retire_ptr_r];
  assign retire_s        = enable & resp_valid & retire_ready_s;
  assign error_set_s     = enable & resp_valid & ~retire_ready_s;

  // Line match search; the entry retiring this cycle has already handed its
  // mask to the response, so it is excluded and a fresh entry gets allocated.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = {PTR_W{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_r[i] && (line_r[i] == req_line_s) &&
          !(retire_s && (retire_ptr_r == PTR_W'(i)))) begin
        hit_s     = 1'b1;
        hit_idx_s = PTR_W'(i);
      end else begin
        hit_s     = hit_s;
        hit_idx_s = hit_idx_s;
      end
    end
  end

  assign full_s    = (count_r == CNT_W'(DEPTH));
  assign req_ready = enable & (~full_s | hit_s);
  assign accept_s  = req_valid & req_ready;
  assign alloc_s   = accept_s & ~hit_s;
  assign merge_s   = accept_s & hit_s;
  assign out_valid = enable & head_issuable_s;
  assign issue_s   = out_valid & out_ready;

  // Data outputs, zeroed whenever the addressed entry is not in the right phase.
  always_comb begin
    if (head_issuable_s) begin
      out_address     = {line_r[issue_ptr_r], {OFFSET_W{1'b0}}};
      out_thread_mask = mask_r[issue_ptr_r];
    end else begin
      out_address     = {ADDR_W{1'b0}};
      out_thread_mask = {NUM_THREADS{1'b0}};
    end
    if (retire_ready_s) begin
      resp_address     = {line_r[retire_ptr_r], {OFFSET_W{1'b0}}};
      resp_thread_mask = mask_r[retire_ptr_r];
    end else begin
      resp_address     = {ADDR_W{1'b0}};
      resp_thread_mask = {NUM_THREADS{1'b0}};
    end
  end

  // Entry status, pointers, occupancy and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r      <= {DEPTH{1'b0}};
      issued_r     <= {DEPTH{1'b0}};
      tail_r       <= {PTR_W{1'b0}};
      issue_ptr_r  <= {PTR_W{1'b0}};
      retire_ptr_r <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      error_r      <= 1'b0;
    end else begin
      if (alloc_s) begin
        valid_r[tail_r]  <= 1'b1;
        issued_r[tail_r] <= 1'b0;
        tail_r           <= tail_r + PTR_W'(1);
      end
      if (issue_s) begin
        issued_r[issue_ptr_r] <= 1'b1;
        issue_ptr_r           <= issue_ptr_r + PTR_W'(1);
      end
      if (retire_s) begin
        valid_r[retire_ptr_r]  <= 1'b0;
        issued_r[retire_ptr_r] <= 1'b0;
        retire_ptr_r           <= retire_ptr_r + PTR_W'(1);
      end
      case ({alloc_s, retire_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (error_set_s) begin
        error_r <= 1'b1;
      end
    end
  end

  // Line/mask payload; not reset, qualified by valid_r everywhere it is read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_s && (tail_r == PTR_W'(i))) begin
        line_r[i] <= req_line_s;
        mask_r[i] <= req_thread_oh;
      end else if (merge_s && (hit_idx_s == PTR_W'(i))) begin
        mask_r[i] <= mask_r[i] | req_thread_oh;
      end
    end
  end

  assign count = count_r;
  assign error = error_r;

endmodule

// File: tb/tb_imiss_merge_queue.sv
// Self-checking bench for imiss_merge_queue: directed vector table, corner
// sequences, and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_imiss_merge_queue;
  localparam int NT = 8;
  localparam int D  = 8;
  localparam int AW = 32;
  localparam int OW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_address = '0;
  logic [NT-1:0] req_thread_oh = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_address;
  logic [NT-1:0] out_thread_mask;
  logic          resp_valid = 1'b0;
  logic [AW-1:0] resp_address;
  logic [NT-1:0] resp_thread_mask;
  logic [3:0]    count;
  logic          error;

  always #5 clk = ~clk;

  imiss_merge_queue #(.NUM_THREADS(NT), .DEPTH(D), .ADDR_W(AW), .OFFSET_W(OW)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
    .req_thread_oh(req_thread_oh),
    .out_valid(out_valid), .out_ready(out_ready), .out_address(out_address),
    .out_thread_mask(out_thread_mask),
    .resp_valid(resp_valid), .resp_address(resp_address),
    .resp_thread_mask(resp_thread_mask),
    .count(count), .error(error)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit en, input bit rv, input logic [31:0] a,
                       input logic [7:0] th, input bit ordy, input bit rsp);
    enable = en; req_valid = rv; req_address = a; req_thread_oh = th;
    out_ready = ordy; resp_valid = rsp;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    drive(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit en; bit rv; logic [31:0] addr; logic [7:0] th; bit ordy; bit rsp;
    bit e_rdy; bit e_ov; logic [31:0] e_oa; logic [7:0] e_om;
    logic [31:0] e_ra; logic [7:0] e_rm; logic [3:0] e_cnt;
  } vec_t;
  vec_t vt[$];

  function automatic void v(bit en, bit rv, logic [31:0] a, logic [7:0] th, bit ordy, bit rsp,
                            bit rdy, bit ov, logic [31:0] oa, logic [7:0] om,
                            logic [31:0] ra, logic [7:0] rm, logic [3:0] cnt);
    vec_t x;
    x.en = en; x.rv = rv; x.addr = a; x.th = th; x.ordy = ordy; x.rsp = rsp;
    x.e_rdy = rdy; x.e_ov = ov; x.e_oa = oa; x.e_om = om;
    x.e_ra = ra; x.e_rm = rm; x.e_cnt = cnt;
    vt.push_back(x);
  endfunction

  // Reference model: ordered list of outstanding lines, oldest first.
  typedef struct { logic [25:0] line; logic [7:0] mask; bit issued; } ment_t;
  ment_t mq[$];
  bit    m_err;

  task automatic model_cycle(input bit en, input bit rv, input logic [31:0] a,
                             input logic [7:0] th, input bit ordy, input bit rsp);
    int n, ni, hit_j;
    bit issuable, has_resp, ret, rdy, ov;
    logic [31:0] oa, ra;
    logic [7:0] om, rm;
    logic [25:0] line;
    ment_t ne;
    line = a[31:6];
    n = mq.size();
    ni = 0;
    foreach (mq[j]) if (mq[j].issued) ni++;
    issuable = (ni < n);
    has_resp = (ni > 0);
    ov = en && issuable;
    oa = issuable ? {mq[ni].line, 6'b0} : 32'h0;
    om = issuable ? mq[ni].mask : 8'h00;
    ra = has_resp ? {mq[0].line, 6'b0} : 32'h0;
    rm = has_resp ? mq[0].mask : 8'h00;
    ret = en && rsp && has_resp;
    hit_j = -1;
    for (int j = 0; j < n; j++)
      if (hit_j < 0 && !(ret && j == 0) && mq[j].line == line) hit_j = j;
    rdy = en && (n < D || hit_j >= 0);
    drive(en, rv, a, th, ordy, rsp);
    #2;
    chk("rnd_req_ready", {31'b0, req_ready}, {31'b0, rdy});
    chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, ov});
    chk("rnd_out_address", out_address, oa);
    chk("rnd_out_mask", {24'b0, out_thread_mask}, {24'b0, om});
    chk("rnd_resp_address", resp_address, ra);
    chk("rnd_resp_mask", {24'b0, resp_thread_mask}, {24'b0, rm});
    chk("rnd_count", {28'b0, count}, n);
    chk("rnd_error", {31'b0, error}, {31'b0, m_err});
    if (rv && rdy && hit_j >= 0) mq[hit_j].mask = mq[hit_j].mask | th;
    if (ov && ordy) mq[ni].issued = 1'b1;
    if (en && rsp && !has_resp) m_err = 1'b1;
    if (ret) void'(mq.pop_front());
    if (rv && rdy && hit_j < 0) begin
      ne.line = line; ne.mask = th; ne.issued = 1'b0;
      mq.push_back(ne);
    end
    tick();
  endtask

  task automatic do_reset;
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mq.delete();
    m_err = 1'b0;
  endtask

  initial begin
    // en rv addr th ordy rsp | rdy ov oa om ra rm cnt
    v(1,0,32'h0,   8'h00,0,0, 1,0,32'h0,8'h00,32'h0,8'h00,0);
    v(1,1,32'h1040,8'h01,0,0, 1,0,32'h0,8'h00,32'h0,8'h00,0);
    v(1,0,32'h0,   8'h00,0,0, 1,1,32'h1040,8'h01,32'h0,8'h00,1);
    v(1,0,32'h0,   8'h00,1,0, 1,1,32'h1040,8'h01,32'h0,8'h00,1);
    v(1,0,32'h0,   8'h00,0,0, 1,0,32'h0,8'h00,32'h1040,8'h01,1);
    v(1,0,32'h0,   8'h00,0,1, 1,0,32'h0,8'h00,32'h1040,8'h01,1);
    v(1,0,32'h0,   8'h00,0,0, 1,0,32'h0,8'h00,32'h0,8'h00,0);
    v(1,1,32'h2000,8'h02,0,0, 1,0,32'h0,8'h00,32'h0,8'h00,0);
    v(1,0,32'h0,   8'h00,1,0, 1,1,32'h2000,8'h02,32'h0,8'h00,1);
    v(1,1,32'h2010,8'h08,0,0, 1,0,32'h0,8'h00,32'h2000,8'h02,1);
    v(1,0,32'h0,   8'h00,0,0, 1,0,32'h0,8'h00,32'h2000,8'h0A,1);
    v(1,0,32'h0,   8'h00,0,1, 1,0,32'h0,8'h00,32'h2000,8'h0A,1);
    v(1,0,32'h0,   8'h00,0,0, 1,0,32'h0,8'h00,32'h0,8'h00,0);
    v(1,1,32'h3000,8'h01,0,0, 1,0,32'h0,8'h00,32'h0,8'h00,0);
    v(1,0,32'h0,   8'h00,1,0, 1,1,32'h3000,8'h01,32'h0,8'h00,1);
    v(1,1,32'h3000,8'h04,0,1, 1,0,32'h0,8'h00,32'h3000,8'h01,1);
    v(1,0,32'h0,   8'h00,0,0, 1,1,32'h3000,8'h04,32'h0,8'h00,1);
    v(1,0,32'h0,   8'h00,1,0, 1,1,32'h3000,8'h04,32'h0,8'h00,1);
    v(1,0,32'h0,   8'h00,0,1, 1,0,32'h0,8'h00,32'h3000,8'h04,1);
    v(1,0,32'h0,   8'h00,0,0, 1,0,32'h0,8'h00,32'h0,8'h00,0);
    v(0,1,32'h4004,8'h10,1,0, 0,0,32'h0,8'h00,32'h0,8'h00,0);
    v(1,0,32'h0,   8'h00,0,0, 1,0,32'h0,8'h00,32'h0,8'h00,0);
    v(1,1,32'h5000,8'h01,0,0, 1,0,32'h0,8'h00,32'h0,8'h00,0);
    v(1,0,32'h0,   8'h00,1,0, 1,1,32'h5000,8'h01,32'h0,8'h00,1);
    v(0,0,32'h0,   8'h00,0,1, 0,0,32'h0,8'h00,32'h5000,8'h01,1);
    v(1,0,32'h0,   8'h00,0,0, 1,0,32'h0,8'h00,32'h5000,8'h01,1);
    v(1,0,32'h0,   8'h00,0,1, 1,0,32'h0,8'h00,32'h5000,8'h01,1);
    v(1,0,32'h0,   8'h00,0,0, 1,0,32'h0,8'h00,32'h0,8'h00,0);

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_count", {28'b0, count}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_req_ready_disabled", {31'b0, req_ready}, 32'd0);

    // Directed table
    foreach (vt[k]) begin
      drive(vt[k].en, vt[k].rv, vt[k].addr, vt[k].th, vt[k].ordy, vt[k].rsp);
      #2;
      chk($sformatf("v%0d_req_ready", k), {31'b0, req_ready}, {31'b0, vt[k].e_rdy});
      chk($sformatf("v%0d_out_valid", k), {31'b0, out_valid}, {31'b0, vt[k].e_ov});
      chk($sformatf("v%0d_out_address", k), out_address, vt[k].e_oa);
      chk($sformatf("v%0d_out_mask", k), {24'b0, out_thread_mask}, {24'b0, vt[k].e_om});
      chk($sformatf("v%0d_resp_address", k), resp_address, vt[k].e_ra);
      chk($sformatf("v%0d_resp_mask", k), {24'b0, resp_thread_mask}, {24'b0, vt[k].e_rm});
      chk($sformatf("v%0d_count", k), {28'b0, count}, {28'b0, vt[k].e_cnt});
      tick();
    end
    chk("table_error", {31'b0, error}, 32'd0);

    // Full queue: new line refused, merge into an existing line accepted
    for (int k = 0; k < D; k++) begin
      drive(1'b1, 1'b1, 32'h10000 + k * 32'h40, 8'(1 << k), 1'b0, 1'b0);
      #2;
      chk($sformatf("fill%0d_ready", k), {31'b0, req_ready}, 32'd1);
      tick();
    end
    idle();
    #2;
    chk("full_count", {28'b0, count}, 32'd8);
    drive(1'b1, 1'b1, 32'h20000, 8'h80, 1'b0, 1'b0);
    #2;
    chk("full_new_line_ready", {31'b0, req_ready}, 32'd0);
    tick();
    drive(1'b1, 1'b1, 32'h100C5, 8'h20, 1'b0, 1'b0);
    #2;
    chk("full_merge_ready", {31'b0, req_ready}, 32'd1);
    tick();
    idle();
    #2;
    chk("full_count_after_merge", {28'b0, count}, 32'd8);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
      #2;
      chk($sformatf("full_issue%0d_addr", k), out_address, 32'h10000 + k * 32'h40);
      tick();
    end
    idle();
    #2;
    chk("full_merged_addr", out_address, 32'h100C0);
    chk("full_merged_mask", {24'b0, out_thread_mask}, 32'h28);
    chk("full_resp_mask", {24'b0, resp_thread_mask}, 32'h01);

    // Asynchronous reset mid-stream
    #1;
    reset = 1'b1;
    #1;
    chk("arst_count", {28'b0, count}, 32'd0);
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_out_address", out_address, 32'h0);
    chk("arst_resp_address", resp_address, 32'h0);
    chk("arst_resp_mask", {24'b0, resp_thread_mask}, 32'h0);
    tick();
    reset = 1'b0;

    // Protocol errors: response with nothing issued
    drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("err_disabled_resp", {31'b0, error}, 32'd0);
    drive(1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 1'b1);
    tick();
    chk("err_set", {31'b0, error}, 32'd1);
    chk("err_count", {28'b0, count}, 32'd0);
    idle();
    tick();
    tick();
    chk("err_sticky", {31'b0, error}, 32'd1);
    chk("err_out_valid", {31'b0, out_valid}, 32'd0);
    do_reset();
    chk("err_cleared", {31'b0, error}, 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      bit en, rv, ordy, rsp, any_issued;
      logic [31:0] a;
      any_issued = 1'b0;
      foreach (mq[j]) if (mq[j].issued) any_issued = 1'b1;
      en   = ($urandom_range(0, 9) != 0);
      rv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 1) != 0);
      rsp  = any_issued && ($urandom_range(0, 2) == 0);
      a    = 32'h8000 + $urandom_range(0, 11) * 32'h40 + $urandom_range(0, 63);
      model_cycle(en, rv, a, 8'(1 << $urandom_range(0, 7)), ordy, rsp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
